// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises 10-bit command frames to the RAM (rx_valid 11 cycles after SS_n falls)
// and serialises RAM read data onto MISO; no backpressure, a read waits at most TX_WAIT_MAX cycles for tx_valid.
module spi_slave_ctrl #(
    parameter int ADDR_SIZE   = 8,
    parameter int TX_WAIT_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [ADDR_SIZE+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [ADDR_SIZE-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   rd_err
);
    localparam int FW = ADDR_SIZE + 2;
    localparam int CW = $clog2(FW + 1);
    localparam int WW = $clog2(TX_WAIT_MAX + 1);
    localparam int TW = $clog2(ADDR_SIZE + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [FW-2:0]        r_shift;
    logic                 r_rd_addr_flag;
    logic                 r_hold;
    logic                 r_wait;
    logic [WW-1:0]        r_wait_cnt;
    logic                 r_tx_busy;
    logic [TW-1:0]        r_tx_cnt;
    logic [ADDR_SIZE-1:0] r_tx_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_rd_addr_flag <= 1'b0;
            r_hold         <= 1'b0;
            r_wait         <= 1'b0;
            r_wait_cnt     <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_cnt       <= '0;
            r_tx_shift     <= '0;
            MISO           <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rd_err         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rd_err   <= 1'b0;
            MISO     <= 1'b0;
            if (SS_n) begin
                if (r_state != IDLE) begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    r_hold     <= 1'b0;
                    r_wait     <= 1'b0;
                    r_wait_cnt <= '0;
                    r_tx_busy  <= 1'b0;
                    r_tx_cnt   <= '0;
                    // Losing a read mid-serialisation consumes the pending address.
                    if (r_tx_busy)
                        r_rd_addr_flag <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: r_state <= CHK_CMD;
                    CHK_CMD: begin
                        r_shift <= {{(FW-2){1'b0}}, MOSI};
                        r_cnt   <= CW'(1);
                        if (!MOSI)
                            r_state <= WRITE;
                        else if (r_rd_addr_flag)
                            r_state <= READ_DATA;
                        else
                            r_state <= READ_ADD;
                    end
                    default: begin
                        if (r_tx_busy) begin
                            MISO       <= r_tx_shift[ADDR_SIZE-1];
                            r_tx_shift <= r_tx_shift << 1;
                            r_tx_cnt   <= r_tx_cnt + 1'b1;
                            if (r_tx_cnt == TW'(ADDR_SIZE - 1)) begin
                                r_tx_busy      <= 1'b0;
                                r_hold         <= 1'b1;
                                r_rd_addr_flag <= 1'b0;
                            end
                        end else if (r_wait) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                            // The edge right after rx_valid is blind so a same-cycle tx_valid is not taken.
                            if (tx_valid && r_wait_cnt != '0) begin
                                r_tx_shift <= tx_data;
                                r_tx_cnt   <= '0;
                                r_tx_busy  <= 1'b1;
                                r_wait     <= 1'b0;
                            end else if (r_wait_cnt == WW'(TX_WAIT_MAX - 1)) begin
                                rd_err         <= 1'b1;
                                r_wait         <= 1'b0;
                                r_hold         <= 1'b1;
                                r_rd_addr_flag <= 1'b0;
                            end
                        end else if (!r_hold) begin
                            r_shift <= {r_shift[FW-3:0], MOSI};
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == CW'(FW - 1)) begin
                                rx_data  <= {r_shift, MOSI};
                                rx_valid <= 1'b1;
                                r_cnt    <= '0;
                                if (r_state == READ_DATA) begin
                                    r_wait     <= 1'b1;
                                    r_wait_cnt <= '0;
                                end else begin
                                    r_hold <= 1'b1;
                                end
                                if (r_state == READ_ADD)
                                    r_rd_addr_flag <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: directed frames then random frames against a frame-level RAM/protocol model.
module tb_spi_slave_ctrl;
    localparam int TWM = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rd_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_waddr;
    logic [7:0] m_raddr;
    bit         m_flag;

    spi_slave_ctrl #(.ADDR_SIZE(8), .TX_WAIT_MAX(TWM)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic e_rxv, input logic e_miso, input logic e_err);
        @(negedge clk);
        chk({tag, ".rx_valid"}, 10'(rx_valid), 10'(e_rxv));
        chk({tag, ".miso"},     10'(MISO),     10'(e_miso));
        chk({tag, ".rd_err"},   10'(rd_err),   10'(e_err));
    endtask

    // One frame: nbits<10 aborts early; dly = cycle (0 = rx_valid cycle) of the tx_valid pulse, -1 none;
    // rst_cyc = cycle after rx_valid at which reset is applied during a read, -1 none.
    task automatic frame(input logic [9:0] w, input int nbits, input int dly, input int rst_cyc);
        bit         rd_data;
        bit         acc;
        logic [7:0] exp_byte;
        logic       em;
        int         last;
        int         n;
        rd_data = w[9] && m_flag;
        SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
        step("start", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[9-i]; tx_valid = 1'($urandom); tx_data = 8'($urandom);
            step("rx", (i == 9), 1'b0, 1'b0);
            if (i == 9) chk("rx_data", rx_data, w);
        end
        tx_valid = 1'b0;
        if (nbits < 10) begin
            SS_n = 1'b1;
            step("abort", 1'b0, 1'b0, 1'b0);
            return;
        end
        if (!w[9]) begin
            if (!w[8]) m_waddr = w[7:0];
            else       m_mem[m_waddr] = w[7:0];
        end else if (!rd_data) begin
            m_raddr = w[7:0];
            m_flag  = 1'b1;
        end else begin
            acc      = (dly >= 1) && (dly <= TWM - 1);
            exp_byte = m_mem[m_raddr];
            m_flag   = 1'b0;
            last     = acc ? dly + 10 : TWM + 1;
            for (int c = 0; c < last; c++) begin
                MOSI = 1'($urandom);
                tx_valid = (c == dly);
                tx_data = (c == dly) ? exp_byte : 8'($urandom);
                n = c + 1;
                em = (acc && n >= dly + 2 && n <= dly + 9) ? exp_byte[7-(n-dly-2)] : 1'b0;
                step("rd", 1'b0, em, (!acc && n == TWM));
                if (n == rst_cyc) begin
                    rst = 1'b1; SS_n = 1'b1; tx_valid = 1'b0;
                    #1;
                    chk("rst.miso",     10'(MISO),     10'd0);
                    chk("rst.rx_valid", 10'(rx_valid), 10'd0);
                    chk("rst.rd_err",   10'(rd_err),   10'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
        end
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
            step("hold", 1'b0, 1'b0, 1'b0);
        end
        SS_n = 1'b1; tx_valid = 1'b0;
        step("end", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        int dly;
        int nb;
        for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
        m_waddr = 8'h00; m_raddr = 8'h00; m_flag = 1'b0;
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #1;
        chk("reset.miso",     10'(MISO),     10'd0);
        chk("reset.rx_valid", 10'(rx_valid), 10'd0);
        chk("reset.rd_err",   10'(rd_err),   10'd0);
        chk("reset.rx_data",  rx_data,       10'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        frame(10'h015, 10, -1, -1);
        frame(10'h1A5, 10, -1, -1);
        frame(10'h215, 10, -1, -1);
        frame(10'h3C3, 10,  2, -1);
        frame(10'h215, 10, -1, -1);
        frame(10'h300, 10,  1, -1);
        frame(10'h0F0,  5, -1, -1);
        frame(10'h0F0, 10, -1, -1);
        frame(10'h15A, 10, -1, -1);
        frame(10'h2F0, 10, -1, -1);
        frame(10'h3FF, 10, -1, -1);
        frame(10'h2F0, 10, -1, -1);
        frame(10'h300, 10,  0, -1);
        frame(10'h215, 10, -1, -1);
        frame(10'h300, 10, TWM - 1, -1);
        frame(10'h215, 10, -1, -1);
        frame(10'h300, 10,  2, 7);
        frame(10'h215, 10, -1, -1);
        frame(10'h300, 10,  3, -1);

        for (int f = 0; f < 3000; f++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0:       dly = -1;
                1:       dly = 0;
                2:       dly = TWM - 1;
                3:       dly = TWM;
                default: dly = int'($urandom_range(1, 4));
            endcase
            nb = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 9)) : 10;
            frame(10'($urandom), nb, dly, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
